// File: rtl/pps_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pps_rx_pkg : shared types and default parameters for the PPS receiver |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pps_rx_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ACQ    = 2'd1,
    LOCK   = 2'd2
  } pps_state_t;

  localparam int c_SYNC_STAGES_DFLT = 2;
  localparam int c_MIN_WIDTH_DFLT   = 4;
  localparam int c_CNT_W_DFLT       = 27;
  localparam int c_WID_W_DFLT       = 16;
  localparam int c_LOCK_CNT_DFLT    = 3;

endpackage
`default_nettype wire

// File: rtl/pps_in_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pps_in_filter : PPS pin synchronizer, glitch filter, width measure   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pps_in_filter
  import pps_rx_pkg::*;
#(
  parameter int SYNC_STAGES = c_SYNC_STAGES_DFLT,
  parameter int MIN_WIDTH   = c_MIN_WIDTH_DFLT,
  parameter int WID_W       = c_WID_W_DFLT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pps_in,
  input  logic             pol,
  output logic             pps_trig,
  output logic [WID_W-1:0] width,
  output logic             glitch
);

  localparam int                c_HI_W    = $clog2(MIN_WIDTH + 1);
  localparam logic [c_HI_W-1:0] c_HI_MAX  = c_HI_W'(MIN_WIDTH);
  localparam logic [c_HI_W-1:0] c_HI_ARM  = c_HI_W'(MIN_WIDTH - 1);
  localparam logic [WID_W-1:0]  c_WID_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic [c_HI_W-1:0]      r_hi_cnt;
  logic [WID_W-1:0]       r_wcnt;
  logic                   w_s;

  // Until the synchronizer has been refilled after reset its content is not
  // the pin, so the qualified level is forced low regardless of polarity.
  assign w_s = r_fill[SYNC_STAGES-1] & (r_sync[SYNC_STAGES-1] ^ pol);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pps_in};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi_cnt <= '0;
      r_wcnt   <= '0;
      pps_trig <= 1'b0;
      width    <= '0;
      glitch   <= 1'b0;
    end else begin
      pps_trig <= w_s && (r_hi_cnt == c_HI_ARM);
      if (w_s) begin
        if (r_hi_cnt != c_HI_MAX) r_hi_cnt <= r_hi_cnt + 1'b1;
        if (r_wcnt != c_WID_MAX)  r_wcnt   <= r_wcnt + 1'b1;
      end else begin
        r_hi_cnt <= '0;
        r_wcnt   <= '0;
        // r_wcnt is nonzero only in the first low cycle after a high run
        if ((r_wcnt != '0) && (r_hi_cnt == c_HI_MAX)) width <= r_wcnt;
        if ((r_hi_cnt != '0) && (r_hi_cnt < c_HI_MAX)) glitch <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pps_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pps_rx : PPS receiver - edge qualify, period/width measure, lock FSM |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pps_rx
  import pps_rx_pkg::*;
#(
  parameter int SYNC_STAGES = c_SYNC_STAGES_DFLT,
  parameter int MIN_WIDTH   = c_MIN_WIDTH_DFLT,
  parameter int CNT_W       = c_CNT_W_DFLT,
  parameter int WID_W       = c_WID_W_DFLT,
  parameter int LOCK_CNT    = c_LOCK_CNT_DFLT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pps_in,
  input  logic             pol,
  input  logic [CNT_W-1:0] nom_period,
  input  logic [CNT_W-1:0] tol,
  output logic             pps_trig,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [WID_W-1:0] width,
  output logic             miss_pulse,
  output logic             bad_period,
  output logic             locked,
  output logic             glitch
);

  localparam int                c_GC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [c_GC_W-1:0] c_GC_LAST  = c_GC_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  c_PCNT_MAX = '1;

  pps_state_t         r_state, w_state_nxt;
  logic [c_GC_W-1:0]  r_good_cnt, w_good_nxt;
  logic [CNT_W-1:0]   r_pcnt;
  logic [CNT_W:0]     w_pcnt_x, w_nom_x, w_diff, w_miss_lim;
  logic               w_good, w_miss, w_bad, w_drop;

  pps_in_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_WIDTH   (MIN_WIDTH),
    .WID_W       (WID_W)
  ) u_filter (
    .clk      (clk),
    .resetn   (resetn),
    .pps_in   (pps_in),
    .pol      (pol),
    .pps_trig (pps_trig),
    .width    (width),
    .glitch   (glitch)
  );

  // One extra bit keeps the distance and the overdue limit free of wrap.
  assign w_pcnt_x   = {1'b0, r_pcnt};
  assign w_nom_x    = {1'b0, nom_period};
  assign w_diff     = (w_pcnt_x >= w_nom_x) ? (w_pcnt_x - w_nom_x) : (w_nom_x - w_pcnt_x);
  assign w_good     = (w_diff <= {1'b0, tol}) && (r_pcnt != c_PCNT_MAX);
  assign w_miss_lim = w_nom_x + {1'b0, tol} + (CNT_W + 1)'(1);
  assign w_miss     = !pps_trig && (r_pcnt != '0) && (w_pcnt_x == w_miss_lim);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad       = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      SEARCH: begin
        if (pps_trig) begin
          w_state_nxt = ACQ;
          w_good_nxt  = '0;
        end
      end
      ACQ: begin
        if (pps_trig) begin
          if (w_good) begin
            w_good_nxt = r_good_cnt + 1'b1;
            if (r_good_cnt == c_GC_LAST) w_state_nxt = LOCK;
          end else begin
            w_bad      = 1'b1;
            w_good_nxt = '0;
          end
        end else if (w_miss) begin
          w_state_nxt = SEARCH;
          w_drop      = 1'b1;
        end
      end
      LOCK: begin
        if (pps_trig) begin
          if (!w_good) begin
            w_bad       = 1'b1;
            w_good_nxt  = '0;
            w_state_nxt = ACQ;
          end
        end else if (w_miss) begin
          w_state_nxt = SEARCH;
          w_drop      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= SEARCH;
      r_good_cnt <= '0;
      r_pcnt     <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      miss_pulse <= 1'b0;
      bad_period <= 1'b0;
      locked     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      locked     <= (w_state_nxt == LOCK);
      miss_pulse <= w_miss;
      bad_period <= w_bad;
      period_vld <= pps_trig && (r_pcnt != '0);
      if (pps_trig && (r_pcnt != '0)) period <= r_pcnt;
      if (pps_trig)                                    r_pcnt <= CNT_W'(1);
      else if (w_drop)                                 r_pcnt <= '0;
      else if ((r_pcnt != '0) && (r_pcnt != c_PCNT_MAX)) r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
